// File: rtl/id_ex_pipe_reg_pkg.sv
// Shared definitions for the ID/EX pipeline register: ALU op classes, halt FSM
// state encodings, the NOP control bundle and the ECALL halt register/value.
package id_ex_pipe_reg_pkg;

   localparam logic [1:0] ALU_OP_ADD = 2'b00;
   localparam logic [1:0] ALU_OP_SUB = 2'b01;
   localparam logic [1:0] ALU_OP_IMM = 2'b10;

   typedef logic [1:0] halt_state_t;
   localparam halt_state_t ST_RUN    = 2'd0;
   localparam halt_state_t ST_DRAIN  = 2'd1;
   localparam halt_state_t ST_HALTED = 2'd2;

   localparam int CNT_W = 3;

   // The halt condition is "a7 (x17) == 10"; the comparison is done upstream.
   localparam logic [4:0]  ECALL_HALT_REG = 5'd17;
   localparam logic [31:0] ECALL_HALT_VAL = 32'd10;

   typedef struct packed {
      logic       mem_read;
      logic       mem_to_reg;
      logic       mem_write;
      logic       alu_src;
      logic       reg_write;
      logic [1:0] alu_op;
      logic       is_ecall;
   } ctrl_t;

   localparam ctrl_t NOP_CTRL = '{
      mem_read:   1'b0,
      mem_to_reg: 1'b0,
      mem_write:  1'b0,
      alu_src:    1'b0,
      reg_write:  1'b0,
      alu_op:     ALU_OP_ADD,
      is_ecall:   1'b0
   };

endpackage

// File: rtl/id_ex_pipe_reg_halt_drain_fsm.sv
// ECALL-halt sequencer: RUN -> DRAIN (DRAIN_CYCLES edges) -> HALTED, sticky until reset.
module halt_drain_fsm
   import id_ex_pipe_reg_pkg::*;
#(
   parameter int DRAIN_CYCLES = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic load_accept,
   input  logic ecall_halt,
   output logic accepting,
   output logic is_halted
);

   halt_state_t       state;
   logic [CNT_W-1:0]  count;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_RUN;
         count <= '0;
      end else begin
         case (state)
            ST_RUN: begin
               if (load_accept && ecall_halt) begin
                  state <= ST_DRAIN;
                  count <= CNT_W'(DRAIN_CYCLES);
               end
            end
            ST_DRAIN: begin
               count <= count - 1'b1;
               if (count == CNT_W'(1)) state <= ST_HALTED;
            end
            ST_HALTED: state <= ST_HALTED;
            default:   state <= ST_RUN;
         endcase
      end
   end

   assign accepting = (state == ST_RUN);
   assign is_halted = (state == ST_HALTED);

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with bubble/flush/hold and the ECALL-halt drain.
// Optional macro ID_EX_BUBBLE_CNT_EN adds a saturating bubble_count output.
module id_ex_pipe_reg
   import id_ex_pipe_reg_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  id_valid,
   input  logic                  bubble,
   input  logic                  flush,
   input  logic                  hold,
   input  logic                  id_mem_read,
   input  logic                  id_mem_to_reg,
   input  logic                  id_mem_write,
   input  logic                  id_alu_src,
   input  logic                  id_reg_write,
   input  logic [1:0]            id_alu_op,
   input  logic                  id_is_ecall,
   input  logic                  id_halt_cond,
   input  logic [DATA_WIDTH-1:0] id_rs1_data,
   input  logic [DATA_WIDTH-1:0] id_rs2_data,
   input  logic [DATA_WIDTH-1:0] id_imm,
   input  logic [DATA_WIDTH-1:0] id_pc,
   input  logic [4:0]            id_rs1,
   input  logic [4:0]            id_rs2,
   input  logic [4:0]            id_rd,
   input  logic [2:0]            id_funct3,
   input  logic                  id_funct7_b5,
   output logic                  ex_mem_read,
   output logic                  ex_mem_to_reg,
   output logic                  ex_mem_write,
   output logic                  ex_alu_src,
   output logic                  ex_reg_write,
   output logic [1:0]            ex_alu_op,
   output logic                  ex_is_ecall,
   output logic [DATA_WIDTH-1:0] ex_rs1_data,
   output logic [DATA_WIDTH-1:0] ex_rs2_data,
   output logic [DATA_WIDTH-1:0] ex_imm,
   output logic [DATA_WIDTH-1:0] ex_pc,
   output logic [4:0]            ex_rs1,
   output logic [4:0]            ex_rs2,
   output logic [4:0]            ex_rd,
   output logic [2:0]            ex_funct3,
   output logic                  ex_funct7_b5,
   output logic                  ex_valid,
`ifdef ID_EX_BUBBLE_CNT_EN
   output logic [31:0]           bubble_count,
`endif
   output logic                  is_halted,
   output logic                  accepting
);

   ctrl_t id_ctrl;
   ctrl_t ex_ctrl;
   logic  normal_load;
   logic  load_fields;
   logic  freeze;

   assign id_ctrl = '{
      mem_read:   id_mem_read,
      mem_to_reg: id_mem_to_reg,
      mem_write:  id_mem_write,
      alu_src:    id_alu_src,
      reg_write:  id_reg_write,
      alu_op:     id_alu_op,
      is_ecall:   id_is_ecall
   };

   // Outside RUN the flush/hold/bubble inputs are ignored and NOPs are loaded.
   assign normal_load = ~flush & ~hold & ~bubble;
   assign load_fields = accepting & normal_load & id_valid;
   assign freeze      = accepting & hold & ~flush;

   halt_drain_fsm #(.DRAIN_CYCLES(DRAIN_CYCLES)) u_halt_fsm (
      .clk         (clk),
      .reset       (reset),
      .load_accept (normal_load),
      .ecall_halt  (id_valid & id_is_ecall & id_halt_cond),
      .accepting   (accepting),
      .is_halted   (is_halted)
   );

   // NOTE: every field is reset, not just control, so EX never sees X data
   // feeding the forwarding muxes after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_ctrl      <= NOP_CTRL;
         ex_valid     <= 1'b0;
         ex_rd        <= '0;
         ex_rs1       <= '0;
         ex_rs2       <= '0;
         ex_rs1_data  <= '0;
         ex_rs2_data  <= '0;
         ex_imm       <= '0;
         ex_pc        <= '0;
         ex_funct3    <= '0;
         ex_funct7_b5 <= 1'b0;
      end else if (!freeze) begin
         // Data fields load even on a NOP; only control, rd and valid are killed.
         ex_rs1       <= id_rs1;
         ex_rs2       <= id_rs2;
         ex_rs1_data  <= id_rs1_data;
         ex_rs2_data  <= id_rs2_data;
         ex_imm       <= id_imm;
         ex_pc        <= id_pc;
         ex_funct3    <= id_funct3;
         ex_funct7_b5 <= id_funct7_b5;
         ex_valid     <= load_fields;
         ex_ctrl      <= load_fields ? id_ctrl : NOP_CTRL;
         ex_rd        <= load_fields ? id_rd : 5'd0;
      end
   end

`ifdef ID_EX_BUBBLE_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bubble_count <= '0;
      end else if (accepting && (flush || (!hold && bubble)) && (bubble_count != '1)) begin
         bubble_count <= bubble_count + 32'd1;
      end
   end
`endif

   assign ex_mem_read   = ex_ctrl.mem_read;
   assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
   assign ex_mem_write  = ex_ctrl.mem_write;
   assign ex_alu_src    = ex_ctrl.alu_src;
   assign ex_reg_write  = ex_ctrl.reg_write;
   assign ex_alu_op     = ex_ctrl.alu_op;
   assign ex_is_ecall   = ex_ctrl.is_ecall;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed self-checking bench for id_ex_pipe_reg (DRAIN_CYCLES = 3).
module tb_id_ex_pipe_reg;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        id_valid, bubble, flush, hold;
   logic        id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write;
   logic [1:0]  id_alu_op;
   logic        id_is_ecall, id_halt_cond;
   logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic [2:0]  id_funct3;
   logic        id_funct7_b5;
   logic        ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write;
   logic [1:0]  ex_alu_op;
   logic        ex_is_ecall;
   logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [2:0]  ex_funct3;
   logic        ex_funct7_b5, ex_valid, is_halted, accepting;
`ifdef ID_EX_BUBBLE_CNT_EN
   logic [31:0] bubble_count;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   id_ex_pipe_reg #(.DATA_WIDTH(32), .DRAIN_CYCLES(3)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .bubble(bubble), .flush(flush), .hold(hold),
      .id_mem_read(id_mem_read), .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write),
      .id_alu_src(id_alu_src), .id_reg_write(id_reg_write), .id_alu_op(id_alu_op),
      .id_is_ecall(id_is_ecall), .id_halt_cond(id_halt_cond),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_pc(id_pc),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3), .id_funct7_b5(id_funct7_b5),
      .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write),
      .ex_alu_src(ex_alu_src), .ex_reg_write(ex_reg_write), .ex_alu_op(ex_alu_op),
      .ex_is_ecall(ex_is_ecall), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
      .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
      .ex_funct3(ex_funct3), .ex_funct7_b5(ex_funct7_b5), .ex_valid(ex_valid),
`ifdef ID_EX_BUBBLE_CNT_EN
      .bubble_count(bubble_count),
`endif
      .is_halted(is_halted), .accepting(accepting)
   );

   task automatic clear_id();
      id_valid = 0; bubble = 0; flush = 0; hold = 0;
      id_mem_read = 0; id_mem_to_reg = 0; id_mem_write = 0; id_alu_src = 0; id_reg_write = 0;
      id_alu_op = 2'b00; id_is_ecall = 0; id_halt_cond = 0;
      id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_pc = 0;
      id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_funct3 = 0; id_funct7_b5 = 0;
   endtask

   // Inputs change #1 after a rising edge; outputs are sampled at the same point.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_alu(input logic [4:0] rd, input logic [31:0] imm, input logic [31:0] pc);
      clear_id();
      id_valid = 1; id_reg_write = 1; id_alu_src = 1; id_alu_op = 2'b10;
      id_rd = rd; id_imm = imm; id_pc = pc; id_rs1 = 5'd2; id_rs1_data = 32'hA5A5_0001;
   endtask

   task automatic test_reset();
      clear_id();
      #2 reset = 1;
      #2;
      checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0h want 0", ex_valid); end
      checks++; if (ex_reg_write !== 1'b0) begin errors++; $display("FAIL reset_reg_write: got %0h want 0", ex_reg_write); end
      checks++; if (ex_imm !== 32'h0) begin errors++; $display("FAIL reset_imm: got %0h want 0", ex_imm); end
      checks++; if (is_halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %0h want 0", is_halted); end
      checks++; if (accepting !== 1'b1) begin errors++; $display("FAIL reset_accepting: got %0h want 1", accepting); end
`ifdef ID_EX_BUBBLE_CNT_EN
      checks++; if (bubble_count !== 32'd0) begin errors++; $display("FAIL reset_bcnt: got %0h want 0", bubble_count); end
`endif
      @(negedge clk) reset = 0;
      step();
   endtask

   task automatic test_plain_load();
      set_alu(5'd5, 32'h0000_0010, 32'h0000_0100);
      step();
      checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL plain_valid: got %0h want 1", ex_valid); end
      checks++; if (ex_reg_write !== 1'b1) begin errors++; $display("FAIL plain_reg_write: got %0h want 1", ex_reg_write); end
      checks++; if (ex_alu_op !== 2'b10) begin errors++; $display("FAIL plain_alu_op: got %0h want 2", ex_alu_op); end
      checks++; if (ex_rd !== 5'd5) begin errors++; $display("FAIL plain_rd: got %0d want 5", ex_rd); end
      checks++; if (ex_imm !== 32'h10) begin errors++; $display("FAIL plain_imm: got %0h want 10", ex_imm); end
      checks++; if (ex_pc !== 32'h100) begin errors++; $display("FAIL plain_pc: got %0h want 100", ex_pc); end
      checks++; if (ex_rs1_data !== 32'hA5A5_0001) begin errors++; $display("FAIL plain_rs1_data: got %0h want a5a50001", ex_rs1_data); end
   endtask

   task automatic test_bubble();
`ifdef ID_EX_BUBBLE_CNT_EN
      logic [31:0] before;
      before = bubble_count;
`endif
      clear_id();
      id_valid = 1; id_mem_read = 1; id_mem_to_reg = 1; id_reg_write = 1; id_alu_src = 1; id_rd = 5'd7;
      bubble = 1;
      step();
      checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid: got %0h want 0", ex_valid); end
      checks++; if (ex_mem_read !== 1'b0) begin errors++; $display("FAIL bubble_mem_read: got %0h want 0", ex_mem_read); end
      checks++; if (ex_reg_write !== 1'b0) begin errors++; $display("FAIL bubble_reg_write: got %0h want 0", ex_reg_write); end
      checks++; if (ex_rd !== 5'd0) begin errors++; $display("FAIL bubble_rd: got %0d want 0", ex_rd); end
`ifdef ID_EX_BUBBLE_CNT_EN
      checks++; if (bubble_count !== before + 32'd1) begin errors++; $display("FAIL bubble_cnt: got %0d want %0d", bubble_count, before + 32'd1); end
`endif
   endtask

   task automatic test_flush_hold();
      clear_id();
      id_valid = 1; id_mem_write = 1; id_alu_src = 1; id_rd = 5'd0;
      flush = 1; hold = 1;
      step();
      checks++; if (ex_mem_write !== 1'b0) begin errors++; $display("FAIL flushhold_mem_write: got %0h want 0", ex_mem_write); end
      checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flushhold_valid: got %0h want 0", ex_valid); end
      set_alu(5'd3, 32'h0000_1234, 32'h0000_0200);
      step();
      // Different instruction in ID while holding; EX must keep rd=3 / imm=0x1234.
      set_alu(5'd9, 32'h0000_0055, 32'h0000_0204);
      hold = 1;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++; if (ex_rd !== 5'd3) begin errors++; $display("FAIL hold_rd[%0d]: got %0d want 3", i, ex_rd); end
         checks++; if (ex_imm !== 32'h1234) begin errors++; $display("FAIL hold_imm[%0d]: got %0h want 1234", i, ex_imm); end
         checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d]: got %0h want 1", i, ex_valid); end
      end
   endtask

   task automatic test_idle_nop();
      set_alu(5'd12, 32'h7, 32'h300);
      id_valid = 0;
      step();
      checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %0h want 0", ex_valid); end
      checks++; if (ex_reg_write !== 1'b0) begin errors++; $display("FAIL idle_reg_write: got %0h want 0", ex_reg_write); end
      checks++; if (ex_alu_op !== 2'b00) begin errors++; $display("FAIL idle_alu_op: got %0h want 0", ex_alu_op); end
      checks++; if (ex_rd !== 5'd0) begin errors++; $display("FAIL idle_rd: got %0d want 0", ex_rd); end
   endtask

   task automatic test_nonhalt_ecall();
      clear_id();
      id_valid = 1; id_is_ecall = 1; id_halt_cond = 0;
      step();
      checks++; if (ex_is_ecall !== 1'b1) begin errors++; $display("FAIL nh_ecall: got %0h want 1", ex_is_ecall); end
      checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL nh_valid: got %0h want 1", ex_valid); end
      checks++; if (accepting !== 1'b1) begin errors++; $display("FAIL nh_accepting: got %0h want 1", accepting); end
      set_alu(5'd4, 32'h4, 32'h400);
      step();
      checks++; if (accepting !== 1'b1) begin errors++; $display("FAIL nh_accepting2: got %0h want 1", accepting); end
      checks++; if (is_halted !== 1'b0) begin errors++; $display("FAIL nh_halted: got %0h want 0", is_halted); end
      checks++; if (ex_rd !== 5'd4) begin errors++; $display("FAIL nh_next_rd: got %0d want 4", ex_rd); end
   endtask

   task automatic set_halt_ecall();
      clear_id();
      id_valid = 1; id_is_ecall = 1; id_halt_cond = 1; id_pc = 32'h500;
   endtask

   task automatic test_ecall_flush_hold();
      set_halt_ecall();
      flush = 1;
      step();
      checks++; if (accepting !== 1'b1) begin errors++; $display("FAIL ecflush_accepting: got %0h want 1", accepting); end
      checks++; if (ex_is_ecall !== 1'b0) begin errors++; $display("FAIL ecflush_ecall: got %0h want 0", ex_is_ecall); end
      set_alu(5'd6, 32'h6, 32'h600);
      step();
      set_halt_ecall();
      hold = 1;
      step();
      checks++; if (accepting !== 1'b1) begin errors++; $display("FAIL echold_accepting: got %0h want 1", accepting); end
      checks++; if (ex_rd !== 5'd6) begin errors++; $display("FAIL echold_rd: got %0d want 6", ex_rd); end
   endtask

   task automatic test_halt_ecall();
      set_halt_ecall();
      step(); // entry edge E
      checks++; if (ex_is_ecall !== 1'b1) begin errors++; $display("FAIL halt_ecall_in_ex: got %0h want 1", ex_is_ecall); end
      checks++; if (accepting !== 1'b0) begin errors++; $display("FAIL halt_accepting: got %0h want 0", accepting); end
      set_alu(5'd8, 32'h8, 32'h504);
      flush = 1; bubble = 1;
      for (int i = 1; i <= 3; i++) begin
         step();
         checks++; if (is_halted !== (i == 3)) begin errors++; $display("FAIL halt_e%0d: got %0h want %0h", i, is_halted, (i == 3)); end
         checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL drain_valid_e%0d: got %0h want 0", i, ex_valid); end
      end
      for (int i = 0; i < 10; i++) begin
         set_alu(5'(i + 1), 32'(i), 32'h600 + 32'(4 * i));
         hold = i[0]; flush = i[1]; bubble = i[2];
         step();
         checks++; if (is_halted !== 1'b1) begin errors++; $display("FAIL halted_sticky[%0d]: got %0h want 1", i, is_halted); end
         checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL halted_valid[%0d]: got %0h want 0", i, ex_valid); end
      end
   endtask

   task automatic test_reset_mid_drain();
      @(negedge clk) reset = 1;
      @(negedge clk) reset = 0;
      step();
      set_halt_ecall();
      step();
      clear_id();
      step(); // one edge into DRAIN
      #2 reset = 1;
      #1;
      checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %0h want 0", ex_valid); end
      checks++; if (accepting !== 1'b1) begin errors++; $display("FAIL rst_mid_accepting: got %0h want 1", accepting); end
      checks++; if (is_halted !== 1'b0) begin errors++; $display("FAIL rst_mid_halted: got %0h want 0", is_halted); end
      #1 reset = 0;
      set_alu(5'd11, 32'h0000_00AB, 32'h700);
      step();
      checks++; if (ex_rd !== 5'd11) begin errors++; $display("FAIL post_rst_rd: got %0d want 11", ex_rd); end
      checks++; if (ex_imm !== 32'hAB) begin errors++; $display("FAIL post_rst_imm: got %0h want ab", ex_imm); end
      checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL post_rst_valid: got %0h want 1", ex_valid); end
      for (int i = 0; i < 4; i++) step();
      checks++; if (is_halted !== 1'b0) begin errors++; $display("FAIL post_rst_halted: got %0h want 0", is_halted); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_plain_load();
      test_bubble();
      test_flush_hold();
      test_idle_nop();
      test_nonhalt_ecall();
      test_ecall_flush_hold();
      test_halt_ecall();
      test_reset_mid_drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
